ram_bus_ctrl: RTL and testbench
===============================

Name: ram_bus_ctrl

Overview:
- Bus-side initiator for the single-port data RAM (14-bit word address, 32-bit data, 4 byte enables, 1-cycle read latency).
- Accepts byte, halfword and word load/store requests from the core's data bus over a valid/ready handshake.
- Converts each request into RAM word address, byte enables and lane-steered write data.
- Returns aligned, sign- or zero-extended read data and an error flag over a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width; bus byte address bits [ADDR_WIDTH+1:2] are used.
- DATA_WIDTH, 32, bus and RAM data width; fixed at 32, and the byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  single clock for bus side and RAM.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  misaligned or illegal-size request.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_wr_data  out  32  lane-steered store data.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_byte_en  out  4  RAM byte enables.
- ram_rd_data  in  32  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - ram_wr_en is forced to 0 combinationally while rst == 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: req_ready = 1. On accept (req_valid && req_ready):
    - ram_addr = req_addr[ADDR_WIDTH+1:2], driven combinationally in the accept cycle.
    - Latch size, unsigned flag, addr[1:0] and err.
    - Store or error -> RESP.
    - Legal load -> RD_WAIT.
  - RD_WAIT: capture ram_rd_data, extract the lane, extend it, load rsp_rdata -> RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE.
  - req_ready = 0 in RD_WAIT and RESP. At most one transaction is outstanding.
- Error rule: err = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0).
  - On error: no RAM write (ram_wr_en = 0), rsp_rdata = 0, rsp_err = 1.
- Store lane steering:
  - byte: be = 4'b0001 << addr[1:0]; wr_data = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wr_data = {2{wdata[15:0]}}.
  - word: be = 4'b1111; wr_data = wdata.
  - ram_wr_en = 1 only in the accept cycle of a legal store.
- Load extraction:
  - byte: lane = rd_data >> (8 * addr[1:0]), bits [7:0].
  - half: lane = rd_data >> (16 * addr[1]), bits [15:0].
  - Sign-extend from the lane MSB unless req_unsigned; word loads pass through.
- Latency (accept at cycle N): store response at N+1; load response at N+2.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses alias with no error.
- Outside the accept cycle: ram_wr_en = 0 and ram_wr_byte_en = 0; ram_addr holds its last value.

Optional Feature:
- Macro RAM_BUS_CTRL_RD_REG_EN.
- Defined: the RAM output register is enabled, giving 2-cycle read latency.
  - An extra state RD_WAIT2 is inserted between RD_WAIT and the capture; load response moves to N+3.
  - Store timing is unchanged.
- Undefined: 1-cycle RAM read path, as described above.

Decomposition:
- Shared package ram_bus_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - FSM state enum.
  - Functions be_gen(size, off) and load_ext(data, size, off, uns).
- One natural sub-module: ram_lane_unit, purely combinational; it performs store lane steering, byte-enable generation and load extraction/extension.
- The FSM stays in ram_bus_ctrl.

Test Plan:
- Word store 0xDEADBEEF at 0x0000_0010, then word load from 0x10:
  - Store: ram_addr = 4, be = 4'hF, wr_en pulses for 1 cycle.
  - Load: rsp_rdata = 0xDEADBEEF at N+2, rsp_err = 0.
- Byte store 0x80 at 0x13, then load byte 0x13:
  - Store: be = 4'b1000.
  - Signed load: rsp_rdata = 0xFFFF_FF80.
  - Unsigned load: rsp_rdata = 0x0000_0080.
- Half load at 0x11 and word store at 0x12:
  - rsp_err = 1, rsp_rdata = 0, ram_wr_en never asserted, memory unchanged.
- Back-pressure: load response with rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0.
  - A new request is accepted only the cycle after the handshake.
- Reset mid-load: rst = 0 in RD_WAIT:
  - Next cycle state IDLE, rsp_valid = 0, no response issued.
  - ram_wr_en = 0 throughout reset.
- With RAM_BUS_CTRL_RD_REG_EN: word load response arrives at N+3 with correct data; store response still at N+1.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and lane helpers for the data-RAM bus controller.
// Size encodings, FSM states, byte-enable and load-extension functions.
package ram_bus_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_WAIT2,
      ST_RESP
   } state_t;

   function automatic logic is_err(
      input logic [1:0] size,
      input logic [1:0] off
   );
      return (size == SZ_ILL) ||
             ((size == SZ_HALF) && off[0]) ||
             ((size == SZ_WORD) && (off != 2'b00));
   endfunction

   function automatic logic [3:0] be_gen(
      input logic [1:0] size,
      input logic [1:0] off
   );
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] load_ext(
      input logic [31:0] data,
      input logic [1:0]  size,
      input logic [1:0]  off,
      input logic        uns
   );
      logic [31:0] sb;
      logic [31:0] sh;
      logic [31:0] res;
      sb  = data >> {off, 3'b000};
      sh  = data >> {off[1], 4'b0000};
      res = data;
      case (size)
         SZ_BYTE: res = uns ? {24'h0, sb[7:0]}
                            : {{24{sb[7]}}, sb[7:0]};
         SZ_HALF: res = uns ? {16'h0, sh[15:0]}
                            : {{16{sh[15]}}, sh[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// Combinational byte-lane unit: store steering, byte enables,
// and load lane extraction with sign/zero extension.
module ram_lane_unit
   import ram_bus_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_off,
   input  logic        i_ld_uns,
   input  logic [31:0] i_rd_data,
   output logic [31:0] o_wr_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_rd_ext
);

   always_comb begin
      o_wr_data = i_wdata;
      case (i_st_size)
         SZ_BYTE: o_wr_data = {4{i_wdata[7:0]}};
         SZ_HALF: o_wr_data = {2{i_wdata[15:0]}};
         default: o_wr_data = i_wdata;
      endcase
   end

   assign o_be     = be_gen(i_st_size, i_st_off);
   assign o_rd_ext = load_ext(i_rd_data, i_ld_size,
                              i_ld_off, i_ld_uns);

endmodule

// File: rtl/ram_bus_ctrl.sv
// Bus-side initiator for the single-port data RAM, one transaction at a time.
// Define RAM_BUS_CTRL_RD_REG_EN for a RAM with its output register enabled.
module ram_bus_ctrl
   import ram_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   output logic [3:0]            ram_wr_byte_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   state_t                r_state;
   logic [1:0]            r_size;
   logic [1:0]            r_off;
   logic                  r_uns;
   logic                  r_err;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic                  w_accept;
   logic                  w_err;
   logic                  w_store;
   logic [3:0]            w_be;
   logic [31:0]           w_wr_data;
   logic [31:0]           w_rd_ext;
   logic                  w_unused;

   // High address bits alias by design.
   assign w_unused = ^req_addr[31:ADDR_WIDTH+2];

   assign req_ready = (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;
   assign w_err     = is_err(req_size, req_addr[1:0]);
   assign w_store   = w_accept && req_we && !w_err;

   assign ram_addr       = w_accept ? req_addr[ADDR_WIDTH+1:2]
                                    : r_addr;
   assign ram_wr_en      = w_store && rst;
   assign ram_wr_byte_en = ram_wr_en ? w_be : 4'b0000;
   assign ram_wr_data    = w_wr_data;

   assign rsp_valid = r_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   ram_lane_unit u_lane (
      .i_st_size (req_size),
      .i_st_off  (req_addr[1:0]),
      .i_wdata   (req_wdata),
      .i_ld_size (r_size),
      .i_ld_off  (r_off),
      .i_ld_uns  (r_uns),
      .i_rd_data (ram_rd_data),
      .o_wr_data (w_wr_data),
      .o_be      (w_be),
      .o_rd_ext  (w_rd_ext)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_size  <= SZ_BYTE;
         r_off   <= 2'b00;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr <= req_addr[ADDR_WIDTH+1:2];
                  r_size <= req_size;
                  r_off  <= req_addr[1:0];
                  r_uns  <= req_unsigned;
                  r_err  <= w_err;
                  if (req_we || w_err) begin
                     r_rdata <= '0;
                     r_valid <= 1'b1;
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_RD_WAIT;
                  end
               end
            end
            ST_RD_WAIT: begin
`ifdef RAM_BUS_CTRL_RD_REG_EN
               r_state <= ST_RD_WAIT2;
`else
               r_rdata <= w_rd_ext;
               r_valid <= 1'b1;
               r_state <= ST_RESP;
`endif
            end
            ST_RD_WAIT2: begin
`ifdef RAM_BUS_CTRL_RD_REG_EN
               r_rdata <= w_rd_ext;
               r_valid <= 1'b1;
               r_state <= ST_RESP;
`else
               r_state <= ST_IDLE;
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with a behavioural single-port RAM.
// Honours RAM_BUS_CTRL_RD_REG_EN for the 2-cycle read path.
module tb_ram_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [13:0] ram_addr;
   logic [31:0] ram_wr_data;
   logic        ram_wr_en;
   logic [3:0]  ram_wr_byte_en;
   logic [31:0] ram_rd_data;

   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   logic [31:0] rd_q1;
   logic [31:0] rd_q2;

   always @(posedge clk) begin
      if (ram_wr_en) begin
         if (ram_wr_byte_en[0]) mem[ram_addr][7:0]   <= ram_wr_data[7:0];
         if (ram_wr_byte_en[1]) mem[ram_addr][15:8]  <= ram_wr_data[15:8];
         if (ram_wr_byte_en[2]) mem[ram_addr][23:16] <= ram_wr_data[23:16];
         if (ram_wr_byte_en[3]) mem[ram_addr][31:24] <= ram_wr_data[31:24];
      end
      rd_q1 <= mem[ram_addr];
      rd_q2 <= rd_q1;
   end

`ifdef RAM_BUS_CTRL_RD_REG_EN
   assign ram_rd_data = rd_q2;
   localparam int LD_LAT = 3;
`else
   assign ram_rd_data = rd_q1;
   localparam int LD_LAT = 2;
`endif

   ram_bus_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .ram_addr       (ram_addr),
      .ram_wr_data    (ram_wr_data),
      .ram_wr_en      (ram_wr_en),
      .ram_wr_byte_en (ram_wr_byte_en),
      .ram_rd_data    (ram_rd_data)
   );

   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic        acc_wr_en;
   logic        acc_rdy;
   logic [3:0]  acc_be;
   logic [13:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [31:0] rsp_d;
   logic        rsp_e;
   logic        wr_seen;

   task automatic issue(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz;
      req_unsigned = uns; req_addr = addr; req_wdata = wd;
      rsp_ready = 1'b1;
      #1;
      acc_rdy = req_ready; acc_wr_en = ram_wr_en;
      acc_be = ram_wr_byte_en; acc_addr = ram_addr;
      acc_wdata = ram_wr_data;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; wr_seen = 1'b0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (ram_wr_en) wr_seen = 1'b1;
         if (rsp_valid) break;
      end
      rsp_d = rsp_rdata; rsp_e = rsp_err;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b1; req_we = 1'b1;
      req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h55; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp got v=%b d=%h e=%b exp 0/0/0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      checks++;
      if (ram_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_wr_en got %b exp 0", ram_wr_en);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", req_ready);
      end
      req_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_word();
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      checks++;
      if (acc_rdy !== 1'b1 || acc_addr !== 14'd4 || acc_be !== 4'hF
          || acc_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL wst_acc got r=%b a=%h be=%h we=%b exp 1/4/f/1",
                  acc_rdy, acc_addr, acc_be, acc_wr_en);
      end
      checks++;
      if (lat !== 1 || rsp_e !== 1'b0 || rsp_d !== 32'h0 || wr_seen) begin
         errors++;
         $display("FAIL wst_rsp got lat=%0d e=%b d=%h ws=%b exp 1/0/0/0",
                  lat, rsp_e, rsp_d, wr_seen);
      end
      checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wst_mem got %h exp deadbeef", mem[4]);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++;
      if (lat !== LD_LAT || rsp_d !== 32'hDEADBEEF || rsp_e !== 1'b0) begin
         errors++;
         $display("FAIL wld got lat=%0d d=%h e=%b exp %0d/deadbeef/0",
                  lat, rsp_d, rsp_e, LD_LAT);
      end
   endtask

   task automatic test_bytes();
      issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680);
      checks++;
      if (acc_be !== 4'b1000 || acc_wdata !== 32'h80808080
          || acc_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL bst got be=%b wd=%h we=%b exp 1000/80808080/1",
                  acc_be, acc_wdata, acc_wr_en);
      end
      checks++;
      if (mem[4] !== 32'h80ADBEEF || lat !== 1) begin
         errors++;
         $display("FAIL bst_mem got %h lat=%0d exp 80adbeef/1", mem[4], lat);
      end
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      checks++;
      if (rsp_d !== 32'hFFFFFF80 || lat !== LD_LAT) begin
         errors++;
         $display("FAIL bld_s got %h lat=%0d exp ffffff80", rsp_d, lat);
      end
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      checks++;
      if (rsp_d !== 32'h00000080) begin
         errors++;
         $display("FAIL bld_u got %h exp 00000080", rsp_d);
      end
      issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      checks++;
      if (rsp_d !== 32'hFFFF80AD) begin
         errors++;
         $display("FAIL hld_s got %h exp ffff80ad", rsp_d);
      end
      issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
      checks++;
      if (rsp_d !== 32'h000000BE) begin
         errors++;
         $display("FAIL bld_off1 got %h exp 000000be", rsp_d);
      end
      issue(1'b1, 2'd1, 1'b0, 32'h16, 32'hAAAA1234);
      checks++;
      if (acc_be !== 4'b1100 || acc_wdata !== 32'h12341234
          || mem[5] !== 32'h12340000) begin
         errors++;
         $display("FAIL hst got be=%b wd=%h m=%h exp 1100/12341234/12340000",
                  acc_be, acc_wdata, mem[5]);
      end
      issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
      checks++;
      if (rsp_d !== 32'h00001234) begin
         errors++;
         $display("FAIL hld_u got %h exp 00001234", rsp_d);
      end
   endtask

   task automatic test_errors();
      issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
      checks++;
      if (rsp_e !== 1'b1 || rsp_d !== 32'h0 || lat !== 1) begin
         errors++;
         $display("FAIL err_hld got e=%b d=%h lat=%0d exp 1/0/1",
                  rsp_e, rsp_d, lat);
      end
      issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h0);
      checks++;
      if (rsp_e !== 1'b1 || rsp_d !== 32'h0 || acc_wr_en !== 1'b0
          || wr_seen !== 1'b0 || acc_be !== 4'h0) begin
         errors++;
         $display("FAIL err_wst got e=%b d=%h we=%b ws=%b be=%h exp 1/0/0/0/0",
                  rsp_e, rsp_d, acc_wr_en, wr_seen, acc_be);
      end
      checks++;
      if (mem[4] !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL err_mem got %h exp 80adbeef", mem[4]);
      end
      issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
      checks++;
      if (rsp_e !== 1'b1 || rsp_d !== 32'h0) begin
         errors++;
         $display("FAIL err_ill got e=%b d=%h exp 1/0", rsp_e, rsp_d);
      end
      issue(1'b0, 2'd2, 1'b0, 32'hFFFF0010, 32'h0);
      checks++;
      if (rsp_e !== 1'b0 || rsp_d !== 32'h80ADBEEF || acc_addr !== 14'd4) begin
         errors++;
         $display("FAIL alias got e=%b d=%h a=%h exp 0/80adbeef/4",
                  rsp_e, rsp_d, acc_addr);
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
      req_unsigned = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 10);
      checks++;
      if (n !== LD_LAT) begin
         errors++;
         $display("FAIL bp_lat got %0d exp %0d", n, LD_LAT);
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h11223344;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80ADBEEF
             || req_ready !== 1'b0 || ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b d=%h r=%b we=%b exp 1/80adbeef/0/0",
                     i, rsp_valid, rsp_rdata, req_ready, ram_wr_en);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ram_wr_en !== 1'b1
          || ram_addr !== 14'd8) begin
         errors++;
         $display("FAIL bp_next got v=%b r=%b we=%b a=%h exp 0/1/1/8",
                  rsp_valid, req_ready, ram_wr_en, ram_addr);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem[8] !== 32'h11223344) begin
         errors++;
         $display("FAIL bp_st got v=%b e=%b m=%h exp 1/0/11223344",
                  rsp_valid, rsp_err, mem[8]);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid_load();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
      req_addr = 32'h10; rsp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid%0d got v=%b r=%b we=%b exp 0/1/0",
                     i, rsp_valid, req_ready, ram_wr_en);
         end
      end
      req_valid = 1'b0;
      rst = 1'b1;
      n_resp_check();
      checks++;
      if (mem[4] !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL rst_mem got %h exp 80adbeef", mem[4]);
      end
   endtask

   task automatic n_resp_check();
      int seen;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rst_norsp got %0d responses exp 0", seen);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      test_reset();
      test_word();
      test_bytes();
      test_errors();
      test_backpressure();
      test_reset_mid_load();
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++;
      if (lat !== LD_LAT || rsp_d !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL post_rst_ld got lat=%0d d=%h exp %0d/80adbeef",
                  lat, rsp_d, LD_LAT);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
